// File: rtl/registro_pipe.sv
// registro_pipe -- elastic pipeline register.
//
// DEPTH stages of WIDTH-bit data, each with its own valid flag, linked by a
// valid/ready handshake. A bubble anywhere in the chain lets the stages above
// it advance, so a stalled output lets upstream stages fill up.
//
// Handshake semantics: a word moves across an interface on a rising CLK edge
// exactly when valid and ready are both high in the cycle before that edge;
// valid never depends on ready, while IN_READY depends combinationally on
// OUT_READY through the readiness chain.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   RESET      synchronous, active-high; clears all valid flags
//   CE         global clock enable; low freezes all state, masks handshakes
//   FLUSH      synchronous clear of all valid flags (data registers hold)
//   IN_VALID   / IN_READY / DATA_IN     upstream side
//   OUT_VALID  / OUT_READY / DATA_OUT   downstream side, DATA_OUT from last stage
//   OCCUPANCY  number of valid stages, 0..DEPTH
//
// Configuration macro REGISTRO_PIPE_CLR_DATA_EN:
//   defined   -> RESET also clears all data registers (DATA_OUT=0 after reset)
//   undefined -> data registers have no reset; DATA_OUT is undefined until the
//                first word reaches the last stage
module registro_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         CE,
    input  logic                         FLUSH,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [WIDTH-1:0]             DATA_IN,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [WIDTH-1:0]             DATA_OUT,
    output logic [$clog2(DEPTH+1)-1:0]   OCCUPANCY
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];

    // r[i]: stage i may load this cycle (it is empty, or its word moves on)
    logic [DEPTH-1:0] r;
    // Source of each stage: the stage below it, or the input port for stage 0
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             adv;
    logic [OCC_W-1:0] occ;

    // Readiness chain, evaluated from the output end back to the input.
    // A running variable keeps the chain free of self-referencing vector bits.
    always_comb begin
        logic rdy;
        rdy = OUT_READY;
        r   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy  = !v_q[i] | rdy;
            r[i] = rdy;
        end
    end

    always_comb begin
        src_v    = '0;
        src_v[0] = IN_VALID;
        src_d[0] = DATA_IN;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v_q[i-1];
            src_d[i] = d_q[i-1];
        end
    end

    // RESET is folded into the advance condition so nothing loads during a
    // reset cycle, even in the build where data registers have no reset.
    assign adv = CE & !FLUSH & !RESET;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (FLUSH) begin
            v_d = '0;
        end else if (adv) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r[i]) begin
                    v_d[i] = src_v[i];
                    d_d[i] = src_d[i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

`ifdef REGISTRO_PIPE_CLR_DATA_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            d_q <= d_d;
        end
    end
`else
    always_ff @(posedge CLK) begin
        d_q <= d_d;
    end
`endif

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(v_q[i]);
        end
    end

    // Both handshakes are masked while RESET, FLUSH or !CE, so no transfer
    // can happen in a cycle where the pipe contents are being discarded.
    assign IN_READY  = adv & r[0];
    assign OUT_VALID = adv & v_q[DEPTH-1];
    assign DATA_OUT  = d_q[DEPTH-1];
    assign OCCUPANCY = occ;

endmodule

// File: tb/tb_registro_pipe.sv
// Bench for registro_pipe (WIDTH=8, DEPTH=3). An item-list model of the pipe
// predicts the outputs every cycle; directed scenarios add literal checks.
module tb_registro_pipe;

    localparam int W = 8;
    localparam int D = 3;

    logic         CLK;
    logic         RESET;
    logic         CE;
    logic         FLUSH;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] DATA_IN;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] DATA_OUT;
    logic [1:0]   OCCUPANCY;

    registro_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .DATA_IN(DATA_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DATA_OUT(DATA_OUT),
        .OCCUPANCY(OCCUPANCY)
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- counters ----------------
    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Words currently in the pipe, output end first, with their stage index.
    typedef struct {
        int           pos;
        logic [W-1:0] data;
    } item_t;
    item_t m_q[$];

    logic [W-1:0] exp_q[$];   // words the model says leave the pipe, in order
    logic [W-1:0] got_q[$];   // words observed leaving the DUT
    int           got_cyc_q[$];
    int           acc_cyc_q[$];

    // Position of the last (input-most) word after one advance, or D if none.
    function automatic int last_newpos(input bit out_fire);
        int limit;
        int np;
        limit = D;
        for (int k = 0; k < m_q.size(); k++) begin
            if (k == 0 && out_fire) continue;
            np = m_q[k].pos + 1;
            if (np > limit - 1) np = limit - 1;
            limit = np;
        end
        return limit;
    endfunction

    function automatic bit m_out_valid();
        return CE && !FLUSH && !RESET && m_q.size() > 0 && m_q[0].pos == D - 1;
    endfunction

    function automatic bit m_in_ready();
        return CE && !FLUSH && !RESET && last_newpos(m_out_valid() && OUT_READY) > 0;
    endfunction

    always @(posedge CLK) begin
        bit fo;
        bit fi;
        int limit;
        int np;
        cyc_n++;
        if (RESET || FLUSH) begin
            m_q.delete();
        end else if (CE) begin
            fo = m_out_valid() && OUT_READY;
            fi = IN_VALID && m_in_ready();
            if (fo) exp_q.push_back(m_q.pop_front().data);
            limit = D;
            for (int k = 0; k < m_q.size(); k++) begin
                np = m_q[k].pos + 1;
                if (np > limit - 1) np = limit - 1;
                m_q[k].pos = np;
                limit = np;
            end
            if (fi) m_q.push_back('{pos: 0, data: DATA_IN});
        end
    end

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("in_ready",  IN_READY,  m_in_ready());
            chk("out_valid", OUT_VALID, m_out_valid());
            chk("occupancy", OCCUPANCY, m_q.size());
            if (m_out_valid()) chk("data_out", DATA_OUT, m_q[0].data);
            if (IN_VALID && IN_READY) acc_cyc_q.push_back(cyc_n);
            if (OUT_VALID && OUT_READY) begin
                got_q.push_back(DATA_OUT);
                got_cyc_q.push_back(cyc_n);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_cyc_q.delete();
        acc_cyc_q.delete();
        exp_q.delete();
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] w);
        bit done;
        done = 0;
        IN_VALID = 1'b1;
        DATA_IN  = w;
        for (int t = 0; t < 20 && !done; t++) begin
            #1;
            done = IN_READY;
            @(posedge CLK);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
        IN_VALID = 1'b0;
    endtask

    task automatic wait_out(input int n);
        for (int t = 0; t < 30 && got_q.size() < n; t++) cyc();
        chk("drain_count", got_q.size(), n);
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] held;

    initial begin
        RESET = 1'b1; CE = 1'b1; FLUSH = 1'b0;
        IN_VALID = 1'b1; DATA_IN = 8'hAA; OUT_READY = 1'b1;

        // Reset behaviour
        cyc();
        chk_en = 1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", OUT_VALID, 0);
            chk("rst_occ", OCCUPANCY, 0);
            chk("rst_in_ready", IN_READY, 0);
`ifdef REGISTRO_PIPE_CLR_DATA_EN
            chk("rst_data_out", DATA_OUT, 8'h00);
`endif
            cyc();
        end
        RESET = 1'b0; IN_VALID = 1'b0;
        #1;
        chk("post_rst_in_ready", IN_READY, 1);
        cyc();

        // Streaming 01..08 with OUT_READY held high
        clear_logs();
        for (int k = 1; k <= 8; k++) begin
            IN_VALID = 1'b1;
            DATA_IN  = W'(k);
            cyc();
        end
        IN_VALID = 1'b0;
        wait_out(8);
        if (got_q.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("stream_word", got_q[k], k + 1);
            chk("stream_latency", got_cyc_q[0] - acc_cyc_q[0], 3);
            chk("stream_no_gap", got_cyc_q[7] - got_cyc_q[0], 7);
            chk("stream_model", exp_q.size(), 8);
        end

        // Stall fill: 5 offered, 3 accepted
        clear_logs();
        OUT_READY = 1'b0;
        send(8'h11); send(8'h12); send(8'h13);
        IN_VALID = 1'b1; DATA_IN = 8'h14;
        cyc(); cyc();
        chk("stall_occ", OCCUPANCY, 3);
        chk("stall_in_ready", IN_READY, 0);
        chk("stall_accepts", acc_cyc_q.size(), 3);
        OUT_READY = 1'b1;
        send(8'h14); send(8'h15);
        wait_out(5);
        if (got_q.size() == 5)
            for (int k = 0; k < 5; k++) chk("stall_order", got_q[k], 8'h11 + k);

        // Bubble collapse: A, idle, B
        clear_logs();
        OUT_READY = 1'b0;
        send(8'hA1);
        cyc();
        send(8'hB2);
        cyc();
        chk("bubble_occ", OCCUPANCY, 2);
        chk("bubble_head", DATA_OUT, 8'hA1);
        OUT_READY = 1'b1;
        wait_out(2);
        if (got_q.size() == 2) begin
            chk("bubble_a", got_q[0], 8'hA1);
            chk("bubble_b", got_q[1], 8'hB2);
            chk("bubble_consec", got_cyc_q[1] - got_cyc_q[0], 1);
        end

        // Flush with a word offered
        clear_logs();
        OUT_READY = 1'b0;
        send(8'hC1); send(8'hC2);
        chk("flush_pre_occ", OCCUPANCY, 2);
        FLUSH = 1'b1; IN_VALID = 1'b1; DATA_IN = 8'h55; OUT_READY = 1'b1;
        #1;
        chk("flush_in_ready", IN_READY, 0);
        chk("flush_out_valid", OUT_VALID, 0);
        cyc();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        #1;
        chk("flush_occ", OCCUPANCY, 0);
        chk("flush_out_valid_after", OUT_VALID, 0);
        for (int k = 0; k < 5; k++) cyc();
        chk("flush_nothing_out", got_q.size(), 0);

        // CE freeze
        clear_logs();
        OUT_READY = 1'b0;
        send(8'hD1); send(8'hD2);
        cyc();
        held = DATA_OUT;
        chk("ce_head", held, 8'hD1);
        CE = 1'b0; OUT_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ce_in_ready", IN_READY, 0);
            chk("ce_out_valid", OUT_VALID, 0);
            chk("ce_data_hold", DATA_OUT, held);
            chk("ce_occ", OCCUPANCY, 2);
            cyc();
        end
        CE = 1'b1;
        wait_out(2);
        if (got_q.size() == 2) begin
            chk("ce_resume_1", got_q[0], 8'hD1);
            chk("ce_resume_2", got_q[1], 8'hD2);
        end

        // Reset mid-operation discards contents
        clear_logs();
        OUT_READY = 1'b0;
        send(8'hE1); send(8'hE2);
        RESET = 1'b1; OUT_READY = 1'b1;
        cyc();
        RESET = 1'b0;
        #1;
        chk("midrst_occ", OCCUPANCY, 0);
        for (int k = 0; k < 5; k++) cyc();
        chk("midrst_nothing_out", got_q.size(), 0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
